seq_arith_nx1b_deser: RTL and testbench
=======================================

# seq_arith_nx1b_deser

Bit-serial to parallel deserializer that sits directly downstream of the 4x1b bit-serial incrementer. It collects the incrementer's serial output, one bit per cycle, LSB first, in implicit 4-bit frames aligned to reset. It presents each completed word on a registered parallel port with a valid/ready handshake. A one-entry output buffer absorbs consumer stalls, and a sticky overflow flag records any word lost while the buffer is full.

## Interface
- NBITS, default 4, frame width in bits. Legal values: 2, 4 or 8. The counter is clog2(NBITS) bits.
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-low reset (0 = reset asserted).
- in_  input  1  serial data bit, LSB of each frame first. Connects to the incrementer's `out`.
- out  output  NBITS  buffered parallel word.
- out_val  output  1  buffer holds a valid word.
- out_rdy  input  1  consumer accepts `out` this cycle.
- ovfl  output  1  sticky flag: at least one completed word was dropped.

## Operation
- Frame counter `cnt` counts 0..NBITS-1 and wraps modulo NBITS.
  - Advances by 1 on every edge with reset deasserted (reset=1).
  - Advances unconditionally; there is no serial-side stall.
- Bit i of a frame is captured on the edge where cnt==i:
  - i < NBITS-1: the bit goes into shift register position i.
  - i = NBITS-1 (last bit): the completed word is {in_, sreg[NBITS-2:0]}.
- The buffer is "free" when out_val==0, or when out_val&&out_rdy in that cycle (drain).
- Load rule on the last-bit edge:
  - If the buffer is free: out ← word and out_val ← 1.
  - Else: the word is dropped, out and out_val hold, and ovfl ← 1.
- Drain rule: if out_val&&out_rdy and no load on that edge, out_val ← 0. `out` holds its last value.
- Simultaneous drain and load: the old word is consumed and the new word is loaded. out_val stays 1 and no overflow is raised.
- out_rdy while out_val==0 has no effect.
- ovfl stays at 1 until reset asserts. Draining does not clear it.
- Reset behaviour:
  - While reset=0: cnt=0, sreg=0, out=0, out_val=0, ovfl=0.
  - Reset asserted mid-frame discards the partial frame.
  - The first edge with reset=1 captures bit 0 of a new frame.
  - This keeps framing aligned with the upstream incrementer, which shares the same reset.

## Timing
- All outputs come directly from flops; there is no combinational path from in_ or out_rdy to any output.
- Latency: the word is visible with out_val=1 in the cycle after the edge that captured its last bit.
  - That is NBITS cycles after the edge that captured bit 0.
- Throughput: one word per NBITS cycles, sustained when out_rdy=1.
- Handshake: a transfer occurs on any edge with out_val&&out_rdy.
  - The consumer must sample `out` in that same cycle.
- Stall headroom: a consumer may hold out_rdy=0 for up to NBITS-1 cycles after out_val rises without loss.
  - The buffer becomes free too late only if it is still full at the next last-bit edge.

## Structure
- Shared package `seq_arith_pkg` holds:
  - the `NBITS` default localparam;
  - the counter width function (clog2).
- The incrementer test bench and this block both import it.
- One natural sub-module, `seq_arith_bit_counter`: modulo-NBITS counter with active-low synchronous reset and a `last` output (cnt==NBITS-1).
- The shift register, output buffer and overflow flag stay in the top module.

## Test plan
- Basic frame, NBITS=4, out_rdy=1:
  - Stimulus: in_ = 1,0,1,1 on consecutive cycles.
  - Required: the next cycle shows out=4'hD with out_val=1; out_val drops to 0 one cycle later.
- Back-to-back frames, out_rdy=1:
  - Stimulus: serial 0x3, then 0xC, then 0xF.
  - Required: out_val pulses once every 4 cycles with out=3, C, F in order; ovfl=0.
- Stall then overflow:
  - Stimulus: out_rdy=0 throughout, serial 0x5 then 0xA.
  - Required: out holds 5 with out_val=1; after the second frame ovfl=1 and out is still 5.
  - Then raise out_rdy: 5 transfers once, out_val=0, ovfl stays 1.
- Simultaneous drain and load:
  - Stimulus: 0x1 buffered, out_rdy=0 until the cycle of the next frame's last-bit edge, then out_rdy=1 in that cycle; next frame is 0x2.
  - Required: 1 transfers, out becomes 2, out_val stays 1, ovfl=0.
- Reset mid-frame:
  - Stimulus: 2 bits of a frame, reset=0 for 2 cycles, then serial 0x9.
  - Required: all outputs are 0 during reset; the first word out is 9, with no stale bits.
- Random run:
  - Stimulus: 40 cycles of random in_, out_rdy and occasional reset.
  - Required: cycle-exact match against a behavioural model of the rules above.

Source files
------------

// File: rtl/seq_arith_pkg.sv
// Shared definitions for the bit-serial arithmetic blocks (incrementer and
// deserializer): default frame width and the frame-counter width helper.
package seq_arith_pkg;

  // Default frame width in bits; legal values are 2, 4 and 8.
  localparam int DEFAULT_NBITS = 4;

  // Width of a counter that walks 0..n-1; never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage : seq_arith_pkg

// File: rtl/seq_arith_nx1b_deser_if.sv
// Serial input plus buffered parallel output with valid/ready handshake and
// the sticky overflow flag. The deserializer is the master; the consumer
// (and the upstream serial source) sits on the slave side.
interface seq_arith_nx1b_deser_if
  import seq_arith_pkg::*;
#(
  parameter int NBITS = DEFAULT_NBITS
);

  logic             in_;
  logic [NBITS-1:0] out;
  logic             out_val;
  logic             out_rdy;
  logic             ovfl;

  modport master (
    input  in_,
    input  out_rdy,
    output out,
    output out_val,
    output ovfl
  );

  modport slave (
    output in_,
    output out_rdy,
    input  out,
    input  out_val,
    input  ovfl
  );

endinterface : seq_arith_nx1b_deser_if

// File: rtl/seq_arith_bit_counter.sv
// Modulo-NBITS frame counter. Advances on every edge out of reset and
// flags the last bit position of the frame.
module seq_arith_bit_counter
  import seq_arith_pkg::*;
#(
  parameter int NBITS = DEFAULT_NBITS,
  parameter int CW    = cnt_width(NBITS)
) (
  input  logic          clk,
  input  logic          reset,   // synchronous, active-low
  output logic [CW-1:0] cnt_o,
  output logic          last_o
);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Next count: wrap explicitly at NBITS-1 so the frame length does not
  // depend on the counter width.
  always_comb begin
    last_o = (cnt_q == CW'(NBITS - 1));
    cnt_d  = last_o ? '0 : cnt_q + 1'b1;
  end

  // Counter register with synchronous active-low reset.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (!reset) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule : seq_arith_bit_counter

// File: rtl/seq_arith_nx1b_deser.sv
// Bit-serial to parallel deserializer. Collects NBITS-bit frames LSB first,
// presents each completed word in a one-entry output buffer with a
// valid/ready handshake and records dropped words in a sticky overflow flag.
module seq_arith_nx1b_deser
  import seq_arith_pkg::*;
#(
  parameter int NBITS = DEFAULT_NBITS
) (
  input  logic                   clk,
  input  logic                   reset,   // synchronous, active-low
  seq_arith_nx1b_deser_if.master bus
);

  localparam int CW = cnt_width(NBITS);

  logic [CW-1:0]    cnt;
  logic             last;

  logic [NBITS-2:0] sreg_q, sreg_d;
  logic [NBITS-1:0] out_q, out_d;
  logic             out_val_q, out_val_d;
  logic             ovfl_q, ovfl_d;

  logic [NBITS-1:0] word;
  logic             drain;
  logic             free;
  logic             load;
  logic             drop;

  seq_arith_bit_counter #(
    .NBITS (NBITS),
    .CW    (CW)
  ) u_counter (
    .clk    (clk),
    .reset  (reset),
    .cnt_o  (cnt),
    .last_o (last)
  );

  // Next-state for shift register, output buffer and overflow flag.
  // NOTE: every signal gets a default at the top of the block, so no path
  // leaves one unassigned and no latch is inferred.
  always_comb begin
    sreg_d    = sreg_q;
    out_d     = out_q;
    out_val_d = out_val_q;
    ovfl_d    = ovfl_q;

    // The last bit bypasses the shift register straight into the word.
    word  = {bus.in_, sreg_q};
    drain = out_val_q && bus.out_rdy;
    free  = !out_val_q || bus.out_rdy;
    load  = last && free;
    drop  = last && !free;

    for (int i = 0; i < NBITS - 1; i++) begin
      if (cnt == CW'(i)) sreg_d[i] = bus.in_;
    end

    // A load wins over a drain on the same edge: the consumer takes the old
    // word while the new one replaces it, so valid stays high.
    if (load) begin
      out_d     = word;
      out_val_d = 1'b1;
    end else if (drain) begin
      out_val_d = 1'b0;
    end

    if (drop) ovfl_d = 1'b1;
  end

  // State registers; reset discards any partial frame and the buffer.
  always_ff @(posedge clk) begin
    if (!reset) begin
      sreg_q    <= '0;
      out_q     <= '0;
      out_val_q <= 1'b0;
      ovfl_q    <= 1'b0;
    end else begin
      sreg_q    <= sreg_d;
      out_q     <= out_d;
      out_val_q <= out_val_d;
      ovfl_q    <= ovfl_d;
    end
  end

  assign bus.out     = out_q;
  assign bus.out_val = out_val_q;
  assign bus.ovfl    = ovfl_q;

endmodule : seq_arith_nx1b_deser

// File: tb/tb_seq_arith_nx1b_deser.sv
// Directed bench for seq_arith_nx1b_deser with NBITS=4, plus a short
// randomised run compared cycle by cycle against a behavioural model.
module tb_seq_arith_nx1b_deser;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  seq_arith_nx1b_deser_if #(.NBITS(4)) bus ();

  seq_arith_nx1b_deser #(.NBITS(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One clock edge; outputs are then sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Two cycles of reset, then release; the next edge captures bit 0.
  task automatic apply_reset();
    reset       = 1'b0;
    bus.in_     = 1'b0;
    bus.out_rdy = 1'b0;
    step();
    step();
    reset = 1'b1;
  endtask

  // Drive one 4-bit frame LSB first, no checks.
  task automatic send_frame(input logic [3:0] w);
    for (int b = 0; b < 4; b++) begin
      bus.in_ = w[b];
      step();
    end
  endtask

  task automatic test_reset();
    apply_reset();
    checks++;
    if (bus.out !== 4'h0) begin
      errors++;
      $display("FAIL reset_out got %h want 0", bus.out);
    end
    checks++;
    if (bus.out_val !== 1'b0) begin
      errors++;
      $display("FAIL reset_val got %b want 0", bus.out_val);
    end
    checks++;
    if (bus.ovfl !== 1'b0) begin
      errors++;
      $display("FAIL reset_ovfl got %b want 0", bus.ovfl);
    end
  endtask

  task automatic test_basic();
    apply_reset();
    bus.out_rdy = 1'b1;
    send_frame(4'hD);   // serial 1,0,1,1
    checks++;
    if (bus.out !== 4'hD || bus.out_val !== 1'b1) begin
      errors++;
      $display("FAIL basic_word got out=%h val=%b want out=d val=1", bus.out, bus.out_val);
    end
    bus.in_ = 1'b0;
    step();
    checks++;
    if (bus.out_val !== 1'b0 || bus.out !== 4'hD) begin
      errors++;
      $display("FAIL basic_drain got out=%h val=%b want out=d val=0", bus.out, bus.out_val);
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] frames [3];
    frames[0] = 4'h3;
    frames[1] = 4'hC;
    frames[2] = 4'hF;
    apply_reset();
    bus.out_rdy = 1'b1;
    for (int f = 0; f < 3; f++) begin
      for (int b = 0; b < 4; b++) begin
        bus.in_ = frames[f][b];
        step();
        checks++;
        if (b < 3) begin
          if (bus.out_val !== 1'b0) begin
            errors++;
            $display("FAIL b2b_idle f=%0d b=%0d got val=%b want 0", f, b, bus.out_val);
          end
        end else if (bus.out_val !== 1'b1 || bus.out !== frames[f]) begin
          errors++;
          $display("FAIL b2b_word f=%0d got out=%h val=%b want out=%h val=1",
                   f, bus.out, bus.out_val, frames[f]);
        end
      end
    end
    checks++;
    if (bus.ovfl !== 1'b0) begin
      errors++;
      $display("FAIL b2b_ovfl got %b want 0", bus.ovfl);
    end
  endtask

  task automatic test_stall_overflow();
    int xfers;
    apply_reset();
    bus.out_rdy = 1'b0;
    send_frame(4'h5);
    checks++;
    if (bus.out !== 4'h5 || bus.out_val !== 1'b1 || bus.ovfl !== 1'b0) begin
      errors++;
      $display("FAIL stall_first got out=%h val=%b ovfl=%b want 5 1 0", bus.out, bus.out_val, bus.ovfl);
    end
    send_frame(4'hA);
    checks++;
    if (bus.out !== 4'h5 || bus.out_val !== 1'b1 || bus.ovfl !== 1'b1) begin
      errors++;
      $display("FAIL stall_drop got out=%h val=%b ovfl=%b want 5 1 1", bus.out, bus.out_val, bus.ovfl);
    end
    bus.out_rdy = 1'b1;
    bus.in_     = 1'b0;
    xfers       = 0;
    for (int c = 0; c < 3; c++) begin
      if (bus.out_val === 1'b1) xfers++;
      step();
    end
    checks++;
    if (xfers != 1) begin
      errors++;
      $display("FAIL stall_xfers got %0d want 1", xfers);
    end
    checks++;
    if (bus.out_val !== 1'b0 || bus.out !== 4'h5 || bus.ovfl !== 1'b1) begin
      errors++;
      $display("FAIL stall_after got out=%h val=%b ovfl=%b want 5 0 1", bus.out, bus.out_val, bus.ovfl);
    end
  endtask

  task automatic test_simul_drain_load();
    logic [3:0] w;
    apply_reset();
    bus.out_rdy = 1'b0;
    send_frame(4'h1);
    w = 4'h2;
    for (int b = 0; b < 3; b++) begin
      bus.in_ = w[b];
      step();
    end
    checks++;
    if (bus.out !== 4'h1 || bus.out_val !== 1'b1) begin
      errors++;
      $display("FAIL simul_held got out=%h val=%b want 1 1", bus.out, bus.out_val);
    end
    bus.in_     = w[3];
    bus.out_rdy = 1'b1;
    step();
    checks++;
    if (bus.out !== 4'h2 || bus.out_val !== 1'b1 || bus.ovfl !== 1'b0) begin
      errors++;
      $display("FAIL simul_load got out=%h val=%b ovfl=%b want 2 1 0", bus.out, bus.out_val, bus.ovfl);
    end
  endtask

  task automatic test_reset_mid_frame();
    apply_reset();
    bus.out_rdy = 1'b0;
    send_frame(4'h7);
    send_frame(4'hA);   // dropped, raises ovfl
    bus.in_ = 1'b1;
    step();
    step();
    reset = 1'b0;
    for (int c = 0; c < 2; c++) begin
      step();
      checks++;
      if (bus.out !== 4'h0 || bus.out_val !== 1'b0 || bus.ovfl !== 1'b0) begin
        errors++;
        $display("FAIL midrst_zero c=%0d got out=%h val=%b ovfl=%b want 0 0 0",
                 c, bus.out, bus.out_val, bus.ovfl);
      end
    end
    reset       = 1'b1;
    bus.out_rdy = 1'b1;
    send_frame(4'h9);
    checks++;
    if (bus.out !== 4'h9 || bus.out_val !== 1'b1 || bus.ovfl !== 1'b0) begin
      errors++;
      $display("FAIL midrst_word got out=%h val=%b ovfl=%b want 9 1 0", bus.out, bus.out_val, bus.ovfl);
    end
  endtask

  task automatic test_random();
    logic [1:0] m_cnt;
    logic [3:0] m_bits;
    logic [3:0] m_out;
    logic       m_val;
    logic       m_ovfl;
    logic [3:0] m_word;
    logic       r_in, r_rdy, r_rst;
    apply_reset();
    m_cnt  = '0;
    m_bits = '0;
    m_out  = '0;
    m_val  = 1'b0;
    m_ovfl = 1'b0;
    for (int c = 0; c < 40; c++) begin
      r_in  = 1'($urandom_range(0, 1));
      r_rdy = 1'($urandom_range(0, 1));
      r_rst = ($urandom_range(0, 11) != 0);
      bus.in_     = r_in;
      bus.out_rdy = r_rdy;
      reset       = r_rst;
      if (!r_rst) begin
        m_cnt  = '0;
        m_bits = '0;
        m_out  = '0;
        m_val  = 1'b0;
        m_ovfl = 1'b0;
      end else begin
        if (m_cnt == 2'd3) begin
          m_word = {r_in, m_bits[2:0]};
          if (!m_val || r_rdy) begin
            m_out = m_word;
            m_val = 1'b1;
          end else begin
            m_ovfl = 1'b1;
          end
        end else begin
          m_bits[m_cnt] = r_in;
          if (m_val && r_rdy) m_val = 1'b0;
        end
        m_cnt = m_cnt + 2'd1;
      end
      step();
      checks++;
      if (bus.out !== m_out || bus.out_val !== m_val || bus.ovfl !== m_ovfl) begin
        errors++;
        $display("FAIL random c=%0d got out=%h val=%b ovfl=%b want %h %b %b",
                 c, bus.out, bus.out_val, bus.ovfl, m_out, m_val, m_ovfl);
      end
    end
    reset = 1'b1;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_basic();
    test_back_to_back();
    test_stall_overflow();
    test_simul_drain_load();
    test_reset_mid_frame();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_seq_arith_nx1b_deser
